board_fetch_arbiter: RTL and testbench

//  Owns the single-port board cell RAM (ROWS x COLS cells, one block_color each).

---
 rtl/board_fetch_arbiter.sv | 147 ++++++++++++++
 tb/tb_board_fetch_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_fetch_arbiter.sv
// Board cell RAM arbiter: display fetch (absolute priority) vs game access.
// Emits registered play_area/block_type one cycle behind DrawX/DrawY.
//
// Ports:
//   Clk, Reset_n            pixel clock, async active-low reset
//   DrawX, DrawY            current VGA pixel position
//   play_area, block_type   registered in-board flag and cell colour
//   gm_req/we/addr/wdata    game request (held until gm_gnt)
//   gm_gnt                  combinational grant pulse
//   gm_rvalid, gm_rdata     read return, cycle after a read grant
//   ram_addr/we/wdata       single-port RAM command
//   ram_rdata               RAM read data, 1-cycle latency
module board_fetch_arbiter #(
    parameter int BOARD_X0 = 240,
    parameter int BOARD_Y0 = 80,
    parameter int CELL_SH  = 4,
    parameter int COLS     = 10,
    parameter int ROWS     = 20
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    output logic       play_area,
    output logic [2:0] block_type,
    input  logic       gm_req,
    input  logic       gm_we,
    input  logic [7:0] gm_addr,
    input  logic [2:0] gm_wdata,
    output logic       gm_gnt,
    output logic       gm_rvalid,
    output logic [2:0] gm_rdata,
    output logic [7:0] ram_addr,
    output logic       ram_we,
    output logic [2:0] ram_wdata,
    input  logic [2:0] ram_rdata
);

    localparam int BW    = COLS << CELL_SH;
    localparam int BH    = ROWS << CELL_SH;
    localparam int NCELL = ROWS * COLS;

    localparam logic [2:0] EMPTY = 3'd0;

    typedef enum logic [1:0] {
        IDLE,
        DISP,
        GM_RD,
        GM_WR
    } owner_e;

    owner_e     owner_q, owner_d;
    logic       rd_oob_q, rd_oob_d;
    logic [2:0] next_cell_q, next_cell_d;
    logic [2:0] cur_cell_q, cur_cell_d;
    logic       play_area_q;
    logic [2:0] block_type_q, block_type_d;

    // Offsets are 11-bit two's complement; a negative offset has bit 10 set,
    // so a single unsigned compare against the extent rejects both sides.
    logic [10:0] lx, dx, dy;
    logic [10:0] row, col;
    logic        in_board, slot, gm_oob;
    logic [7:0]  slot_addr;
    logic [2:0]  cell_now;

    assign lx = {1'b0, DrawX} + 11'd2 - 11'(BOARD_X0);
    assign dx = {1'b0, DrawX} - 11'(BOARD_X0);
    assign dy = {1'b0, DrawY} - 11'(BOARD_Y0);

    assign in_board = (dx < 11'(BW)) && (dy < 11'(BH));

    // Fetch two pixels ahead of each cell's first pixel.
    assign slot = Reset_n
                && (lx < 11'(BW))
                && (dy < 11'(BH))
                && (lx[CELL_SH-1:0] == '0);

    assign row       = dy >> CELL_SH;
    assign col       = lx >> CELL_SH;
    assign slot_addr = 8'(row * 11'(COLS) + col);

    assign gm_oob = {1'b0, gm_addr} >= 9'(NCELL);
    assign gm_gnt = Reset_n && gm_req && !slot;

    always_comb begin
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = '0;
        owner_d   = IDLE;
        rd_oob_d  = 1'b0;
        unique case (1'b1)
            slot: begin
                ram_addr = slot_addr;
                owner_d  = DISP;
            end
            gm_gnt: begin
                ram_addr = gm_addr;
                if (gm_we) begin
                    ram_we    = !gm_oob;
                    ram_wdata = gm_wdata;
                    owner_d   = GM_WR;
                end else begin
                    owner_d  = GM_RD;
                    rd_oob_d = gm_oob;
                end
            end
            default: ;
        endcase
    end

    // On a cell's first pixel the freshly fetched colour is used directly
    // and latched as the current cell for the remaining pixels.
    always_comb begin
        next_cell_d  = next_cell_q;
        if (owner_q == DISP) begin
            next_cell_d = ram_rdata;
        end
        cell_now     = (dx[CELL_SH-1:0] == '0) ? next_cell_q : cur_cell_q;
        cur_cell_d   = cell_now;
        block_type_d = in_board ? cell_now : EMPTY;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            owner_q      <= IDLE;
            rd_oob_q     <= 1'b0;
            next_cell_q  <= EMPTY;
            cur_cell_q   <= EMPTY;
            play_area_q  <= 1'b0;
            block_type_q <= EMPTY;
        end else begin
            owner_q      <= owner_d;
            rd_oob_q     <= rd_oob_d;
            next_cell_q  <= next_cell_d;
            cur_cell_q   <= cur_cell_d;
            play_area_q  <= in_board;
            block_type_q <= block_type_d;
        end
    end

    assign play_area  = play_area_q;
    assign block_type = block_type_q;
    assign gm_rvalid  = (owner_q == GM_RD);
    assign gm_rdata   = (gm_rvalid && !rd_oob_q) ? ram_rdata : EMPTY;

endmodule

// File: tb/tb_board_fetch_arbiter.sv
// Testbench for board_fetch_arbiter with a synchronous RAM model.
// Table vectors for slot/grant decode, scoreboarded pixel sweeps.
module tb_board_fetch_arbiter;

    localparam logic [2:0] EMPTY = 3'd0;
    localparam logic [2:0] RED   = 3'd2;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic [9:0] DrawX = '0;
    logic [9:0] DrawY = '0;
    logic       play_area;
    logic [2:0] block_type;
    logic       gm_req = 1'b0;
    logic       gm_we = 1'b0;
    logic [7:0] gm_addr = '0;
    logic [2:0] gm_wdata = '0;
    logic       gm_gnt;
    logic       gm_rvalid;
    logic [2:0] gm_rdata;
    logic [7:0] ram_addr;
    logic       ram_we;
    logic [2:0] ram_wdata;
    logic [2:0] ram_rdata;

    int n_checks = 0;
    int n_errors = 0;

    board_fetch_arbiter dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .DrawX     (DrawX),
        .DrawY     (DrawY),
        .play_area (play_area),
        .block_type(block_type),
        .gm_req    (gm_req),
        .gm_we     (gm_we),
        .gm_addr   (gm_addr),
        .gm_wdata  (gm_wdata),
        .gm_gnt    (gm_gnt),
        .gm_rvalid (gm_rvalid),
        .gm_rdata  (gm_rdata),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    always #5 Clk = ~Clk;

    // RAM model with a bench-side preload port.
    logic [2:0] mem [256];
    logic [2:0] rd_q = '0;
    logic       tb_we = 1'b0;
    logic [7:0] tb_waddr = '0;
    logic [2:0] tb_wdata = '0;

    always @(posedge Clk) begin
        if (tb_we)
            mem[tb_waddr] <= tb_wdata;
        else if (ram_we)
            mem[ram_addr] <= ram_wdata;
        rd_q <= mem[ram_addr];
    end
    assign ram_rdata = rd_q;

    logic [2:0] board [256];

    typedef struct {
        int         x;
        logic       play;
        logic [2:0] bt;
    } px_t;
    px_t pq[$];
    logic [2:0] rq[$];

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic       req;
        logic       we;
        logic [7:0] addr;
        logic [2:0] wdata;
        logic       e_gnt;
        logic [7:0] e_addr;
        logic       e_we;
    } vec_t;
    vec_t tbl[12];

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic bit tb_slot(input int x, input int y);
        int lx;
        lx = x + 2 - 240;
        return (lx >= 0) && (lx < 160) && (lx % 16 == 0)
            && (y >= 80) && (y < 400);
    endfunction

    task automatic chk_reset(input string tag);
        chk({tag, "_play"},   play_area,  0);
        chk({tag, "_bt"},     block_type, EMPTY);
        chk({tag, "_gnt"},    gm_gnt,     0);
        chk({tag, "_rvalid"}, gm_rvalid,  0);
        chk({tag, "_rdata"},  gm_rdata,   EMPTY);
        chk({tag, "_we"},     ram_we,     0);
        chk({tag, "_addr"},   ram_addr,   0);
        chk({tag, "_wdata"},  ram_wdata,  0);
    endtask

    task automatic chk_px(input px_t g);
        chk($sformatf("px%0d_play", g.x), play_area, g.play);
        chk($sformatf("px%0d_bt", g.x), block_type, g.bt);
    endtask

    task automatic sweep(input int y);
        px_t e;
        px_t g;
        pq.delete();
        gm_req = 1'b0;
        DrawY  = 10'(y);
        for (int x = 236; x <= 402; x++) begin
            tick();
            if (pq.size() > 0) begin
                g = pq.pop_front();
                chk_px(g);
            end
            DrawX  = 10'(x);
            e.x    = x;
            e.play = (x >= 240) && (x < 400) && (y >= 80) && (y < 400);
            e.bt   = EMPTY;
            if (e.play)
                e.bt = board[((y - 80) / 16) * 10 + (x - 240) / 16];
            pq.push_back(e);
            #1;
            if (tb_slot(x, y)) begin
                chk($sformatf("fetch%0d_addr", x), ram_addr,
                    ((y - 80) / 16) * 10 + (x - 238) / 16);
                chk($sformatf("fetch%0d_we", x), ram_we, 0);
            end
        end
        tick();
        if (pq.size() > 0) begin
            g = pq.pop_front();
            chk_px(g);
        end
    endtask

    initial begin
        int stalls;
        int k;

        tbl[0]  = '{10'd238, 10'd80,  1'b1, 1'b0, 8'd13,  3'd0, 1'b0, 8'd0,   1'b0};
        tbl[1]  = '{10'd254, 10'd80,  1'b1, 1'b0, 8'd13,  3'd0, 1'b0, 8'd1,   1'b0};
        tbl[2]  = '{10'd382, 10'd80,  1'b1, 1'b0, 8'd13,  3'd0, 1'b0, 8'd9,   1'b0};
        tbl[3]  = '{10'd398, 10'd80,  1'b1, 1'b0, 8'd13,  3'd0, 1'b1, 8'd13,  1'b0};
        tbl[4]  = '{10'd236, 10'd80,  1'b1, 1'b0, 8'd13,  3'd0, 1'b1, 8'd13,  1'b0};
        tbl[5]  = '{10'd238, 10'd79,  1'b1, 1'b0, 8'd13,  3'd0, 1'b1, 8'd13,  1'b0};
        tbl[6]  = '{10'd238, 10'd399, 1'b1, 1'b0, 8'd13,  3'd0, 1'b0, 8'd190, 1'b0};
        tbl[7]  = '{10'd238, 10'd400, 1'b1, 1'b0, 8'd13,  3'd0, 1'b1, 8'd13,  1'b0};
        tbl[8]  = '{10'd270, 10'd96,  1'b1, 1'b0, 8'd13,  3'd0, 1'b0, 8'd12,  1'b0};
        tbl[9]  = '{10'd255, 10'd80,  1'b1, 1'b0, 8'd13,  3'd0, 1'b1, 8'd13,  1'b0};
        tbl[10] = '{10'd300, 10'd80,  1'b1, 1'b1, 8'd205, RED,  1'b1, 8'd205, 1'b0};
        tbl[11] = '{10'd300, 10'd80,  1'b1, 1'b1, 8'd50,  3'd5, 1'b1, 8'd50,  1'b1};

        // Reset held with a pending request in an in-board, non-slot spot.
        DrawX  = 10'd300;
        DrawY  = 10'd80;
        gm_req = 1'b1;
        tick();
        tick();
        chk_reset("rst0");
        Reset_n = 1'b1;
        #1;
        chk("rst0_rel_gnt", gm_gnt, 1);
        tick();
        gm_req = 1'b0;
        DrawX  = 10'd0;
        DrawY  = 10'd0;

        // Preload: cell 0 CYAN(1), cell 1 RED(2), others (i%7)+1.
        for (int i = 0; i < 256; i++) begin
            tick();
            tb_we    = 1'b1;
            tb_waddr = 8'(i);
            tb_wdata = 3'((i % 7) + 1);
            board[i] = 3'((i % 7) + 1);
        end
        tick();
        tb_we = 1'b0;

        for (int i = 0; i < 12; i++) begin
            tick();
            DrawX    = tbl[i].x;
            DrawY    = tbl[i].y;
            gm_req   = tbl[i].req;
            gm_we    = tbl[i].we;
            gm_addr  = tbl[i].addr;
            gm_wdata = tbl[i].wdata;
            #1;
            chk($sformatf("vec%0d_gnt", i), gm_gnt, tbl[i].e_gnt);
            chk($sformatf("vec%0d_addr", i), ram_addr, tbl[i].e_addr);
            chk($sformatf("vec%0d_we", i), ram_we, tbl[i].e_we);
            if (tbl[i].e_we)
                chk($sformatf("vec%0d_wdata", i), ram_wdata, tbl[i].wdata);
        end
        tick();
        gm_req = 1'b0;
        gm_we  = 1'b0;
        board[50] = 3'd5;

        sweep(80);
        sweep(335);

        // Read held across a display slot: stalls one cycle.
        tick();
        DrawY   = 10'd80;
        DrawX   = 10'd254;
        gm_req  = 1'b1;
        gm_we   = 1'b0;
        gm_addr = 8'd13;
        #1;
        chk("stall_gnt254", gm_gnt, 0);
        tick();
        DrawX = 10'd255;
        #1;
        chk("stall_gnt255", gm_gnt, 1);
        chk("stall_addr255", ram_addr, 13);
        if (gm_gnt)
            rq.push_back(board[13]);
        tick();
        DrawX  = 10'd256;
        gm_req = 1'b0;
        #1;
        chk("stall_rvalid", gm_rvalid, 1);
        if (rq.size() > 0)
            chk("stall_rdata", gm_rdata, rq.pop_front());
        else
            chk("stall_rq_empty", rq.size(), 1);
        tick();
        DrawX = 10'd257;
        #1;
        chk("rvalid_pulse", gm_rvalid, 0);

        // Out-of-range address: write suppressed, read returns EMPTY.
        tick();
        DrawX    = 10'd300;
        gm_req   = 1'b1;
        gm_we    = 1'b1;
        gm_addr  = 8'd205;
        gm_wdata = RED;
        #1;
        chk("oob_wr_gnt", gm_gnt, 1);
        chk("oob_wr_we", ram_we, 0);
        tick();
        gm_we = 1'b0;
        #1;
        chk("oob_rd_gnt", gm_gnt, 1);
        tick();
        gm_req = 1'b0;
        #1;
        chk("oob_rd_rvalid", gm_rvalid, 1);
        chk("oob_rd_rdata", gm_rdata, EMPTY);

        // Continuous writes across one board line.
        stalls = 0;
        k = 0;
        DrawY = 10'd81;
        for (int x = 230; x <= 410; x++) begin
            tick();
            DrawX    = 10'(x);
            gm_req   = 1'b1;
            gm_we    = 1'b1;
            gm_addr  = 8'(100 + (k % 50));
            gm_wdata = 3'((k % 7) + 1);
            #1;
            chk($sformatf("cont%0d_gnt", x), gm_gnt, !tb_slot(x, 81));
            if (gm_gnt)
                k++;
            else
                stalls++;
        end
        chk("cont_stalls", stalls, 10);
        tick();
        gm_req = 1'b0;
        gm_we  = 1'b0;

        // Mid-frame reset with a read grant in flight.
        DrawY = 10'd80;
        DrawX = 10'd250;
        tick();
        DrawX   = 10'd300;
        gm_req  = 1'b1;
        gm_addr = 8'd13;
        #1;
        chk("mid_pre_play", play_area, 1);
        chk("mid_pre_gnt", gm_gnt, 1);
        #1;
        Reset_n = 1'b0;
        #1;
        chk_reset("rst1");
        tick();
        tick();
        chk_reset("rst1_hold");
        Reset_n = 1'b1;
        #1;
        chk("rst1_rel_gnt", gm_gnt, 1);
        tick();
        gm_req = 1'b0;
        #1;
        chk("rst1_rel_rvalid", gm_rvalid, 1);
        tick();

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
